forward_unit: RTL

FORWARD_UNIT -- requirements
Module: forward_unit

---
 rtl/forward_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/forward_unit.sv
// Single-stage EX->EX forwarding with a one-entry holding register that also
// feeds the register-file write port; detects load-use hazards and counts stalls.
module forward_unit #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_Rs1,
    input  logic [REG_AW-1:0] ID_Rs2,
    input  logic              ID_Use_Rs1,
    input  logic              ID_Use_Rs2,
    input  logic              Flush,
    input  logic              EX_Valid,
    input  logic [REG_AW-1:0] EX_Rd,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic [DATA_W-1:0] EX_Result,
    output logic              Forward_Rs1,
    output logic              Forward_Rs2,
    output logic [DATA_W-1:0] Forwarded_reg,
    output logic              Stall,
    output logic              WB_We,
    output logic [REG_AW-1:0] WB_Rd,
    output logic [DATA_W-1:0] WB_Data,
    output logic [7:0]        Stall_Count
);

    logic [REG_AW-1:0] id_rs   [2];
    logic [1:0]        id_use;
    logic [1:0]        hit;
    logic [1:0]        fwd_reg;
    logic [1:0]        fwd_next;
    logic              ex_writes;

    logic              h_valid_reg;
    logic              h_valid_next;
    logic [REG_AW-1:0] h_rd_reg;
    logic [DATA_W-1:0] h_data_reg;
    logic [7:0]        stall_count_reg;

    assign id_rs[0]  = ID_Rs1;
    assign id_rs[1]  = ID_Rs2;
    assign id_use    = {ID_Use_Rs2, ID_Use_Rs1};
    assign ex_writes = EX_Valid & EX_RegWrite;

    // Flush and a bubble in EX both suppress every hit, which also kills Stall.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit[gi] = ID_Valid & ~Flush & id_use[gi] & (id_rs[gi] != '0)
                           & ex_writes & (EX_Rd == id_rs[gi]);
            assign fwd_next[gi] = hit[gi] & ~EX_MemRead & ~Stall;
        end
    endgenerate

    assign Stall        = (|hit) & EX_MemRead;
    assign h_valid_next = ex_writes & ~EX_MemRead & (EX_Rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid_reg     <= 1'b0;
            h_rd_reg        <= '0;
            h_data_reg      <= '0;
            fwd_reg         <= '0;
            stall_count_reg <= '0;
        end else begin
            h_valid_reg <= h_valid_next;
            h_rd_reg    <= EX_Rd;
            h_data_reg  <= EX_Result;
            fwd_reg     <= fwd_next;
            if (Stall && stall_count_reg != 8'hFF) begin
                stall_count_reg <= stall_count_reg + 8'd1;
            end
        end
    end

    assign Forward_Rs1   = fwd_reg[0];
    assign Forward_Rs2   = fwd_reg[1];
    assign Forwarded_reg = h_data_reg;
    assign WB_We         = h_valid_reg;
    assign WB_Rd         = h_rd_reg;
    assign WB_Data       = h_data_reg;
    assign Stall_Count   = stall_count_reg;

endmodule
